// File: rtl/ms_pkg.sv
// Shared types and constants for the msALU sequencer datapath.
// Instruction layout: [9:7] opcode, [6:5] Rx (dest / first source), [4:3] Ry (second source).
package ms_pkg;

  localparam int WIDTH    = 10;
  localparam int REG_BITS = 2;
  localparam int INSTR_W  = 10;

  localparam int OPC_HI = 9;
  localparam int OPC_LO = 7;
  localparam int RX_HI  = 6;
  localparam int RX_LO  = 5;
  localparam int RY_HI  = 4;
  localparam int RY_LO  = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_INV  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_LOAD = 3'b110,
    ALU_MOV  = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEC    = 3'd1,
    S_LDA    = 3'd2,
    S_EXE    = 3'd3,
    S_GO     = 3'd4,
    S_WB     = 3'd5,
    S_WB_IMM = 3'd6,
    S_WB_MOV = 3'd7
  } state_t;

endpackage

// File: rtl/ms_regfile.sv
// Register file for the sequencer: one write port, an operand read port and a debug read port.
// Updates on the falling clock edge; cleared asynchronously by RST.
module ms_regfile #(
  parameter int WIDTH    = 10,
  parameter int REG_BITS = 2
) (
  input  logic                CLKb,
  input  logic                RST,
  input  logic                i_we,
  input  logic [REG_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic [REG_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]    o_rdata,
  input  logic [REG_BITS-1:0] i_dbg_sel,
  output logic [WIDTH-1:0]    o_dbg_data
);

  localparam int DEPTH = 2 ** REG_BITS;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata    = r_mem[i_raddr];
  assign o_dbg_data = r_mem[i_dbg_sel];

endmodule

// File: rtl/ms_alu_seq.sv
// Multi-cycle instruction sequencer in front of msALU; owns the register file and write-back.
// Outputs are registered from the next state so msALU sees clean levels for a whole state.
module ms_alu_seq #(
  parameter int WIDTH    = 10,
  parameter int REG_BITS = 2
) (
  input  logic                CLKb,
  input  logic                RST,
  input  logic                Start,
  input  logic [9:0]          Instr,
  input  logic [WIDTH-1:0]    DIN,
  input  logic [WIDTH-1:0]    Q,
  output logic [WIDTH-1:0]    OP,
  output logic [2:0]          ALUControl,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic                Busy,
  output logic                Done,
  input  logic [REG_BITS-1:0] DbgSel,
  output logic [WIDTH-1:0]    DbgReg
);
  import ms_pkg::*;

  state_t              r_state;
  logic [9:0]          r_ir;
  logic [WIDTH-1:0]    r_imm;

  state_t              w_next;
  alu_op_t             w_opc;
  logic [REG_BITS-1:0] w_rx;
  logic [REG_BITS-1:0] w_ry;
  logic [REG_BITS-1:0] w_raddr;
  logic [WIDTH-1:0]    w_rdata;
  logic [WIDTH-1:0]    w_wdata;
  logic                w_we;

  assign w_opc = alu_op_t'(r_ir[OPC_HI:OPC_LO]);
  assign w_rx  = r_ir[RX_HI:RX_LO];
  assign w_ry  = r_ir[RY_HI:RY_LO];

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = Start ? S_DEC : S_IDLE;
      S_DEC: begin
        if (w_opc == ALU_LOAD)     w_next = S_WB_IMM;
        else if (w_opc == ALU_MOV) w_next = S_WB_MOV;
        else                       w_next = S_LDA;
      end
      S_LDA:   w_next = S_EXE;
      S_EXE:   w_next = S_GO;
      S_GO:    w_next = S_WB;
      default: w_next = S_IDLE;
    endcase
  end

  // Rx is only needed as an operand for LDA; every other read (EXE, GO, MOV source) is Ry.
  assign w_raddr = (w_next == S_LDA) ? w_rx : w_ry;

  always_comb begin
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_WB:     begin w_we = 1'b1; w_wdata = Q;       end
      S_WB_IMM: begin w_we = 1'b1; w_wdata = r_imm;   end
      S_WB_MOV: begin w_we = 1'b1; w_wdata = w_rdata; end
      default:  begin w_we = 1'b0; w_wdata = '0;      end
    endcase
  end

  ms_regfile #(
    .WIDTH   (WIDTH),
    .REG_BITS(REG_BITS)
  ) u_regfile (
    .CLKb      (CLKb),
    .RST       (RST),
    .i_we      (w_we),
    .i_waddr   (w_rx),
    .i_wdata   (w_wdata),
    .i_raddr   (w_raddr),
    .o_rdata   (w_rdata),
    .i_dbg_sel (DbgSel),
    .o_dbg_data(DbgReg)
  );

  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_imm      <= '0;
      OP         <= '0;
      ALUControl <= 3'b000;
      Ain        <= 1'b0;
      Gin        <= 1'b0;
      Gout       <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && Start) begin
        r_ir  <= Instr;
        r_imm <= DIN;
      end
      OP         <= (w_next inside {S_LDA, S_EXE, S_GO}) ? w_rdata : '0;
      ALUControl <= (w_next inside {S_EXE, S_GO}) ? w_opc : ALU_ADD;
      Ain        <= (w_next == S_LDA);
      Gin        <= (w_next == S_EXE);
      Gout       <= (w_next == S_GO);
      Busy       <= (w_next != S_IDLE);
      Done       <= (w_next inside {S_WB, S_WB_IMM, S_WB_MOV});
    end
  end

endmodule

// File: tb/tb_ms_alu_seq.sv
// Bench for ms_alu_seq with a small msALU stand-in looping Q back, a cycle-schedule model
// of the outputs and an architectural register model.
module tb_ms_alu_seq;

  logic       CLKb, RST, Start;
  logic [9:0] Instr, DIN, Q, OP, DbgReg;
  logic [2:0] ALUControl;
  logic       Ain, Gin, Gout, Busy, Done;
  logic [1:0] DbgSel;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  bit chk_en = 0;

  typedef struct packed {
    logic       op_chk;
    logic [9:0] op;
    logic       ctl_chk;
    logic [2:0] ctl;
    logic       ain, gin, gout, busy, done;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] m_reg[4];
  logic [9:0] alu_a, alu_g, alu_q;

  ms_alu_seq #(.WIDTH(10), .REG_BITS(2)) dut (
    .CLKb(CLKb), .RST(RST), .Start(Start), .Instr(Instr), .DIN(DIN), .Q(Q),
    .OP(OP), .ALUControl(ALUControl), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .Busy(Busy), .Done(Done), .DbgSel(DbgSel), .DbgReg(DbgReg)
  );

  initial begin
    CLKb = 1'b1;
    forever #10 CLKb = ~CLKb;
  end

  // msALU stand-in: A on Ain, G = f(A, OP) on Gin, Q <= G on Gout, all on the falling edge.
  always @(negedge CLKb or posedge RST) begin
    if (RST) begin
      alu_a <= '0; alu_g <= '0; alu_q <= '0;
    end else begin
      if (Ain) alu_a <= OP;
      if (Gin) begin
        case (ALUControl)
          3'b000:  alu_g <= alu_a + OP;
          3'b001:  alu_g <= alu_a - OP;
          3'b010:  alu_g <= 10'd0 - OP;
          3'b011:  alu_g <= alu_a & OP;
          3'b100:  alu_g <= alu_a | OP;
          3'b101:  alu_g <= alu_a ^ OP;
          default: alu_g <= alu_g;
        endcase
      end
      if (Gout) alu_q <= alu_g;
    end
  end
  assign Q = alu_q;

  function automatic logic [9:0] mk(input logic [2:0] opc, input logic [1:0] rx, input logic [1:0] ry);
    return {opc, rx, ry, 3'b000};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Expected per-cycle outputs from the accepting edge onward.
  task automatic push_sched(input logic [9:0] ins);
    logic [2:0] opc;
    logic [1:0] rx, ry;
    exp_t x;
    opc = ins[9:7]; rx = ins[6:5]; ry = ins[4:3];
    x = '0; x.busy = 1; exp_q.push_back(x);
    if (opc >= 3'd6) begin
      x = '0; x.busy = 1; x.done = 1; exp_q.push_back(x);
    end else begin
      x = '0; x.busy = 1; x.op_chk = 1; x.op = m_reg[rx]; x.ain = 1; exp_q.push_back(x);
      x = '0; x.busy = 1; x.op_chk = 1; x.op = m_reg[ry]; x.ctl_chk = 1; x.ctl = opc; x.gin = 1;
      exp_q.push_back(x);
      x = '0; x.busy = 1; x.op_chk = 1; x.op = m_reg[ry]; x.ctl_chk = 1; x.ctl = opc; x.gout = 1;
      exp_q.push_back(x);
      x = '0; x.busy = 1; x.done = 1; exp_q.push_back(x);
    end
  endtask

  task automatic model_apply(input logic [9:0] ins, input logic [9:0] din);
    logic [1:0] rx, ry;
    rx = ins[6:5]; ry = ins[4:3];
    case (ins[9:7])
      3'd0: m_reg[rx] = m_reg[rx] + m_reg[ry];
      3'd1: m_reg[rx] = m_reg[rx] - m_reg[ry];
      3'd2: m_reg[rx] = 10'd0 - m_reg[ry];
      3'd3: m_reg[rx] = m_reg[rx] & m_reg[ry];
      3'd4: m_reg[rx] = m_reg[rx] | m_reg[ry];
      3'd5: m_reg[rx] = m_reg[rx] ^ m_reg[ry];
      3'd6: m_reg[rx] = din;
      default: m_reg[rx] = m_reg[ry];
    endcase
  endtask

  // Per-cycle output comparison, sampled on the rising edge (mid-state).
  initial begin
    exp_t x;
    forever begin
      @(posedge CLKb);
      if (!RST && chk_en) begin
        if (exp_q.size() > 0) x = exp_q.pop_front();
        else x = '0;
        if (Busy === 1'b1) busy_cnt++;
        if (Done === 1'b1) done_cnt++;
        n_vec++;
        if (Ain !== x.ain || Gin !== x.gin || Gout !== x.gout || Busy !== x.busy ||
            Done !== x.done || (x.op_chk && OP !== x.op) || (x.ctl_chk && ALUControl !== x.ctl)) begin
          n_err++;
          $display("FAIL cycle_outputs t=%0t: got op=%h ctl=%b ain=%b gin=%b gout=%b busy=%b done=%b; expected op=%h(chk %b) ctl=%b(chk %b) ain=%b gin=%b gout=%b busy=%b done=%b",
                   $time, OP, ALUControl, Ain, Gin, Gout, Busy, Done, x.op, x.op_chk, x.ctl,
                   x.ctl_chk, x.ain, x.gin, x.gout, x.busy, x.done);
        end
      end
    end
  end

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      DbgSel = 2'(i);
      #1;
      check($sformatf("R%0d", i), 32'(DbgReg), 32'(m_reg[i]));
    end
  endtask

  task automatic lit(input string name, input logic [1:0] sel, input logic [9:0] expv);
    DbgSel = sel;
    #1;
    check(name, 32'(DbgReg), 32'(expv));
  endtask

  // Entered one tick after the accepting edge (state DEC); leaves in the Done cycle.
  task automatic wait_done(input logic [9:0] ins, input logic [9:0] din, input bit inject);
    int lat;
    lat = 1;
    while (Done !== 1'b1 && lat < 20) begin
      @(negedge CLKb); #1;
      lat++;
      if (inject) begin
        if (lat == 3) begin
          Start = 1'b1; Instr = mk(3'b110, 2'd3, 2'd0); DIN = 10'h155;
        end else begin
          Start = 1'b0;
        end
      end
    end
    check("latency", 32'(lat), (ins[9:7] >= 3'd6) ? 32'd2 : 32'd5);
    if (Done === 1'b1) model_apply(ins, din);
  endtask

  task automatic run(input logic [9:0] ins, input logic [9:0] din, input bit hold2, input bit inject);
    @(posedge CLKb); #1;
    Instr = ins; DIN = din; Start = 1'b1;
    push_sched(ins);
    @(negedge CLKb); #1;
    if (!hold2) Start = 1'b0;
    wait_done(ins, din, hold2 ? 1'b0 : inject);
    if (hold2) begin
      exp_q.push_back('0);
      push_sched(ins);
      @(negedge CLKb); #1;
      @(negedge CLKb); #1;
      Start = 1'b0;
      wait_done(ins, din, 1'b0);
    end
    @(negedge CLKb); #1;
    check_regs();
  endtask

  initial begin
    int b0, d0;
    logic [9:0] ins;
    bit hold, inj;
    RST = 1'b0; Start = 1'b0; Instr = '0; DIN = '0; DbgSel = '0;
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    #2 RST = 1'b1;
    #1;
    check("reset_outputs", 32'({OP, ALUControl, Ain, Gin, Gout, Busy, Done}), 32'd0);
    check_regs();
    @(posedge CLKb); #1;
    RST = 1'b0;
    chk_en = 1'b1;

    // Scenario 1: LOAD, LOAD, ADD
    run(mk(3'b110, 2'd0, 2'd0), 10'd25, 0, 0);
    run(mk(3'b110, 2'd1, 2'd0), 10'd7, 0, 0);
    run(mk(3'b000, 2'd0, 2'd1), 10'd0, 0, 0);
    lit("s1_add_r0", 2'd0, 10'd32);

    // Start held high re-issues ADD R0,R1 once more: 32+7+7
    run(mk(3'b000, 2'd0, 2'd1), 10'd0, 1, 0);
    lit("held_start_r0", 2'd0, 10'd46);

    // Scenario 2: SUB wraps, INV negates
    run(mk(3'b110, 2'd2, 2'd0), 10'd5, 0, 0);
    run(mk(3'b110, 2'd3, 2'd0), 10'd9, 0, 0);
    run(mk(3'b001, 2'd2, 2'd3), 10'd0, 0, 0);
    lit("s2_sub_r2", 2'd2, 10'h3FC);
    run(mk(3'b010, 2'd2, 2'd3), 10'd0, 0, 0);
    lit("s2_inv_r2", 2'd2, 10'h3F7);

    // Scenario 3: logic ops with fresh R0
    run(mk(3'b110, 2'd1, 2'd0), 10'h0F0, 0, 0);
    run(mk(3'b110, 2'd0, 2'd0), 10'h2AA, 0, 0);
    run(mk(3'b011, 2'd0, 2'd1), 10'd0, 0, 0);
    lit("s3_and", 2'd0, 10'h0A0);
    run(mk(3'b110, 2'd0, 2'd0), 10'h2AA, 0, 0);
    run(mk(3'b100, 2'd0, 2'd1), 10'd0, 0, 0);
    lit("s3_or", 2'd0, 10'h2FA);
    run(mk(3'b110, 2'd0, 2'd0), 10'h2AA, 0, 0);
    run(mk(3'b101, 2'd0, 2'd1), 10'd0, 0, 0);
    lit("s3_xor", 2'd0, 10'h25A);

    // Scenario 4: Busy width and single Done on ADD (Rx==Ry doubles)
    b0 = busy_cnt; d0 = done_cnt;
    run(mk(3'b000, 2'd1, 2'd1), 10'd0, 0, 0);
    check("busy_cycles", 32'(busy_cnt - b0), 32'd5);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    lit("s4_double_r1", 2'd1, 10'h1E0);

    // Scenario 5: Start during EXE is ignored
    run(mk(3'b000, 2'd0, 2'd1), 10'd0, 0, 1);

    // Scenario 6: reset during GO aborts
    @(posedge CLKb); #1;
    Instr = mk(3'b000, 2'd0, 2'd1); DIN = '0; Start = 1'b1;
    push_sched(Instr);
    @(negedge CLKb); #1;
    Start = 1'b0;
    repeat (3) @(negedge CLKb);
    #3;
    RST = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    #1;
    check("abort_outputs", 32'({OP, ALUControl, Ain, Gin, Gout, Busy, Done}), 32'd0);
    check_regs();
    @(posedge CLKb); #1;
    RST = 1'b0;
    run(mk(3'b110, 2'd0, 2'd0), 10'h123, 0, 0);
    run(mk(3'b111, 2'd3, 2'd0), 10'd0, 0, 0);
    lit("s6_mov_r3", 2'd3, 10'h123);

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      ins  = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      hold = ($urandom_range(0, 5) == 0);
      inj  = !hold && ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge CLKb);
      run(ins, 10'($urandom_range(0, 1023)), hold, inj);
    end

    repeat (3) @(posedge CLKb);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
